// File: rtl/exins_responder.sv
// exins_responder: fixed-latency instruction fetch responder backed by a loadable word array.
// Define EXINS_PREFETCH_EN to speculatively fetch the next sequential word after each response.
module exins_responder #(
    parameter int          LATENCY   = 2,
    parameter int          AWIDTH    = 10,
    parameter logic [31:0] INST_INIT = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              exIns_ren,
    input  logic [31:0]       exIns_addr,
    output logic              exIns_valid,
    output logic [31:0]       exIns_in,
    input  logic              ld_we,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    output logic              busy,
    output logic              err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    // A single-cycle latency has no WAIT cycle at all: capture goes straight to RESP.
    localparam logic [1:0] LOAD_STATE = (LATENCY == 1) ? RESP : WAIT;

    logic [1:0]  state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [31:0] la, la_nx;
    logic [31:0] mem [2**AWIDTH];
    logic        hit, in_range;

    assign hit      = exIns_addr == la;
    assign in_range = ((la >> (AWIDTH + 2)) == 32'd0) && (la[1:0] == 2'b00);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        la_nx    = la;
        case (state)
            IDLE: if (exIns_ren) begin
                la_nx    = exIns_addr;
                cnt_nx   = CNT_LOAD;
                state_nx = LOAD_STATE;
            end
            WAIT: if (!exIns_ren) begin
                state_nx = IDLE;
            end else if (!hit) begin
                la_nx    = exIns_addr;
                cnt_nx   = CNT_LOAD;
                state_nx = LOAD_STATE;
            end else begin
                cnt_nx   = cnt - 4'd1;
                state_nx = (cnt <= 4'd1) ? RESP : WAIT;
            end
`ifdef EXINS_PREFETCH_EN
            RESP: begin
                la_nx    = la + 32'd4;
                cnt_nx   = CNT_LOAD;
                state_nx = LOAD_STATE;
            end
`else
            RESP: state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            la    <= 32'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            la    <= la_nx;
            if (state == RESP && !in_range)
                err <= 1'b1;
        end
    end

    // Array has no reset so loaded code survives nrst; reads are combinational (old data on same-edge write).
    always_ff @(posedge clk) begin
        if (ld_we)
            mem[ld_addr] <= ld_data;
    end

    assign exIns_valid = (state == RESP) && exIns_ren && hit;
    assign exIns_in    = (exIns_valid && in_range) ? mem[la[AWIDTH+1:2]] : INST_INIT;
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_exins_responder.sv
// tb_exins_responder: directed self-checking bench for exins_responder at default parameters.
module tb_exins_responder;
    logic        clk, nrst, exIns_ren, exIns_valid, ld_we, busy, err;
    logic [31:0] exIns_addr, exIns_in, ld_data;
    logic [9:0]  ld_addr;
    int          errors = 0;
    int          checks = 0;

`ifdef EXINS_PREFETCH_EN
    localparam int SPACING = 2;
    localparam logic BUSY_AFTER = 1'b1;
`else
    localparam int SPACING = 3;
    localparam logic BUSY_AFTER = 1'b0;
`endif

    exins_responder dut (
        .clk(clk), .nrst(nrst), .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
        .exIns_valid(exIns_valid), .exIns_in(exIns_in), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic step(input logic ren, input logic [31:0] addr, input logic we,
                        input logic [9:0] la, input logic [31:0] ld);
        @(posedge clk);
        #1;
        exIns_ren  = ren;
        exIns_addr = addr;
        ld_we      = we;
        ld_addr    = la;
        ld_data    = ld;
        @(negedge clk);
    endtask

    task automatic test_reset;
        nrst = 1'b0; exIns_ren = 1'b0; exIns_addr = 32'd0;
        ld_we = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
        #2;
        checks++; if (exIns_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", exIns_valid); end
        checks++; if (exIns_in !== 32'h0000_0013) begin errors++; $display("FAIL reset_in got=%h want=00000013", exIns_in); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        @(negedge clk);
        nrst = 1'b1;
        step(0, 0, 1, 10'd0,  32'h0010_0093);
        step(0, 0, 1, 10'd1,  32'h0020_0113);
        step(0, 0, 1, 10'd2,  32'h0030_0193);
        step(0, 0, 1, 10'd16, 32'hDEAD_BEEF);
        step(0, 0, 0, 10'd0,  32'd0);
    endtask

    task automatic test_basic;
        step(1, 0, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_c0 got valid=%b busy=%b want 0 0", exIns_valid, busy); end
        step(1, 0, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_c1 got valid=%b busy=%b want 0 1", exIns_valid, busy); end
        step(1, 0, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_c2 got valid=%b busy=%b want 1 1", exIns_valid, busy); end
        checks++; if (exIns_in !== 32'h0010_0093) begin errors++; $display("FAIL basic_data got=%h want=00100093", exIns_in); end
        step(0, 0, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b0 || busy !== BUSY_AFTER) begin errors++; $display("FAIL basic_after got valid=%b busy=%b want 0 %b", exIns_valid, busy, BUSY_AFTER); end
        step(0, 0, 0, 0, 0);
        checks++; if (exIns_in !== 32'h0000_0013 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got in=%h busy=%b want 00000013 0", exIns_in, busy); end
    endtask

    task automatic test_branch;
        step(1, 32'h8, 0, 0, 0);
        step(1, 32'h40, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b0) begin errors++; $display("FAIL branch_switch got=%b want=0", exIns_valid); end
        step(1, 32'h40, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b0) begin errors++; $display("FAIL branch_wait got=%b want=0", exIns_valid); end
        step(1, 32'h40, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b1 || exIns_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL branch_resp got valid=%b in=%h want 1 deadbeef", exIns_valid, exIns_in); end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_misaligned;
        step(1, 32'h6, 0, 0, 0);
        step(1, 32'h6, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mis_wait got valid=%b err=%b want 0 0", exIns_valid, err); end
        step(1, 32'h6, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b1 || exIns_in !== 32'h0000_0013) begin errors++; $display("FAIL mis_resp got valid=%b in=%h want 1 00000013", exIns_valid, exIns_in); end
        step(0, 0, 0, 0, 0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err got=%b want=1", err); end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_sticky got=%b want=1", err); end
    endtask

    task automatic test_reset_midwait;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
        nrst = 1'b0;
        exIns_ren = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || err !== 1'b0 || exIns_valid !== 1'b0) begin errors++; $display("FAIL rst_async got busy=%b err=%b valid=%b want 0 0 0", busy, err, exIns_valid); end
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0);
            checks++; if (exIns_valid !== 1'b0 || exIns_in !== 32'h0000_0013 || busy !== 1'b0) begin errors++; $display("FAIL rst_release cyc=%0d got valid=%b in=%h busy=%b want 0 00000013 0", k, exIns_valid, exIns_in, busy); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [3];
        int t [3];
        int i = 0;
        exp[0] = 32'h0010_0093; exp[1] = 32'h0020_0113; exp[2] = 32'h0030_0193;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step(i < 3, 32'(4 * i), 0, 0, 0);
            if (exIns_valid && i < 3) begin
                checks++; if (exIns_in !== exp[i]) begin errors++; $display("FAIL seq_data idx=%0d got=%h want=%h", i, exIns_in, exp[i]); end
                t[i] = cyc;
                i++;
            end
        end
        checks++;
        if (i != 3) begin
            errors++; $display("FAIL seq_timeout got=%0d want=3 responses", i);
        end else begin
            checks++; if (t[1] - t[0] != SPACING) begin errors++; $display("FAIL seq_gap01 got=%0d want=%0d", t[1] - t[0], SPACING); end
            checks++; if (t[2] - t[1] != SPACING) begin errors++; $display("FAIL seq_gap12 got=%0d want=%0d", t[2] - t[1], SPACING); end
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_load_during_resp;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 10'd0, 32'h1111_1111);
        checks++; if (exIns_valid !== 1'b1 || exIns_in !== 32'h0010_0093) begin errors++; $display("FAIL ld_old got valid=%b in=%h want 1 00100093", exIns_valid, exIns_in); end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++; if (exIns_valid !== 1'b1 || exIns_in !== 32'h1111_1111) begin errors++; $display("FAIL ld_new got valid=%b in=%h want 1 11111111", exIns_valid, exIns_in); end
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_branch;
        test_back_to_back;
        test_misaligned;
        test_reset_midwait;
        test_load_during_resp;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exins_responder.md
EXINS_RESPONDER -- requirements
Module: exins_responder

Interface
REQ-001 Parameter LATENCY, default 2: cycles from request capture to exIns_valid; legal range 1..15.
REQ-002 Parameter AWIDTH, default 10: word-address width of the internal instruction array (2**AWIDTH words).
REQ-003 Parameter INST_INIT, default 32'h0000_0013: NOP word returned on error and driven whenever not valid.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 nrst  in  1  reset; asynchronous assertion, active-low.
REQ-006 exIns_ren  in  1  fetch request; level, held by the initiator until it sees exIns_valid.
REQ-007 exIns_addr  in  32  byte address of the requested instruction.
REQ-008 exIns_valid  out  1  response valid; the initiator consumes the word in any cycle where exIns_ren & exIns_valid.
REQ-009 exIns_in  out  32  instruction word.
REQ-010 ld_we  in  1  loader write strobe.
REQ-011 ld_addr  in  AWIDTH  loader word address.
REQ-012 ld_data  in  32  loader write data.
REQ-013 busy  out  1  high in WAIT or RESP.
REQ-014 err  out  1  sticky flag for out-of-range or misaligned requests.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, and RESP, plus a 4-bit down-counter cnt and a latched byte address la.
REQ-016 In IDLE with exIns_ren=1, the block SHALL latch la<=exIns_addr, load cnt<=LATENCY-1, and go to WAIT.
REQ-017 In WAIT, if exIns_ren=1 and exIns_addr==la, the block SHALL decrement cnt and go to RESP on the edge where cnt==0.
REQ-018 In WAIT, if exIns_ren=1 and exIns_addr!=la (branch), the block SHALL relatch la, reload cnt<=LATENCY-1, and stay in WAIT.
REQ-019 In WAIT, if exIns_ren=0, the block SHALL return to IDLE (abort).
REQ-020 In RESP, exIns_valid SHALL equal exIns_ren & (exIns_addr==la), combinationally.
REQ-021 exIns_valid SHALL be 0 in IDLE and WAIT.
REQ-022 RESP SHALL last exactly one cycle, then go to IDLE (unless EXINS_PREFETCH_EN applies).
REQ-023 A request held from cycle N SHALL see exIns_valid in cycle N+LATENCY.
REQ-024 exIns_in SHALL be mem[la[AWIDTH+1:2]] when exIns_valid=1, and INST_INIT otherwise.
REQ-025 la is in range iff la[31:AWIDTH+2]==0 and la[1:0]==0; otherwise, the block SHALL still respond with exIns_valid per REQ-020, with exIns_in=INST_INIT, and set err on the RESP edge.
REQ-026 The array SHALL be read combinationally and written on a clock edge when ld_we=1.
REQ-027 A load to the address being served in a RESP cycle SHALL return the old word; the new word is visible from the next cycle.
REQ-028 ld_we SHALL be accepted in every state and SHALL never stall the FSM.
REQ-029 busy SHALL be (state!=IDLE).

Reset
REQ-030 nrst=0 SHALL immediately force state=IDLE, cnt=0, la=0, err=0, exIns_valid=0, exIns_in=INST_INIT, and busy=0.
REQ-031 Reset SHALL NOT clear array contents.
REQ-032 Reset asserted in WAIT or RESP SHALL discard the in-flight request; no valid is issued after release until a new request completes per REQ-023.
REQ-033 err SHALL be cleared only by reset.

Configuration
REQ-034 With macro EXINS_PREFETCH_EN defined, RESP SHALL, on its exit edge, set la<=la+4 and cnt<=LATENCY-1 and enter WAIT (speculative next word).
REQ-035 With EXINS_PREFETCH_EN defined, REQ-018 and REQ-019 SHALL apply unchanged to the speculative fetch (mismatch restarts, no request aborts).
REQ-036 With EXINS_PREFETCH_EN defined, sequential throughput SHALL be one word per LATENCY cycles.
REQ-037 Without EXINS_PREFETCH_EN, RESP SHALL always go to IDLE, and sequential throughput SHALL be one word per LATENCY+1 cycles.

Verification
REQ-038 Load mem[0]=32'h0010_0093, LATENCY=2, hold ren with addr=0 from cycle 5 -> exIns_valid=1 and exIns_in=32'h0010_0093 in cycle 7 only; busy is high in cycles 6-7.
REQ-039 Request 0x8, then in WAIT switch addr to 0x40 (mem[16]=32'hDEAD_BEEF) -> no valid for 0x8; valid with 32'hDEAD_BEEF exactly LATENCY cycles after the switch.
REQ-040 Request 0x6 (misaligned) -> valid with 32'h0000_0013 after LATENCY cycles; err=1 thereafter, until nrst.
REQ-041 Assert nrst=0 mid-WAIT, release, keep ren=0 -> exIns_valid stays 0, exIns_in=32'h0000_0013, and busy=0.
REQ-042 Sequential fetches 0x0, 0x4, 0x8 with an initiator model, LATENCY=2 -> valids spaced 3 cycles without EXINS_PREFETCH_EN and 2 cycles with it.
REQ-043 Write ld_addr=0 with 32'h1111_1111 during the RESP cycle for addr 0 -> that response returns the old word; the next fetch of 0 returns 32'h1111_1111.
